// File: rtl/align_pkg.sv
// align_pkg: shared definitions for the alignment-tile job controller.
//   state_t     controller state encoding
//   BASE_W      bits per base
//   PAIR_W      bits per {r, q} base pair
//   NULL_BASE   sentinel base emitted by tbmodule on its first active cycle
//   GAP_BASE    base code for an alignment gap
//   is_null_pair  true for the {NULL_BASE, NULL_BASE} sentinel pair
package align_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SCORE      = 2'd1,
    ST_WAIT_SPACE = 2'd2,
    ST_TRACE      = 2'd3
  } state_t;

  localparam int BASE_W = 3;
  localparam int PAIR_W = 2 * BASE_W;

  localparam logic [BASE_W-1:0] NULL_BASE = 3'b111;
  localparam logic [BASE_W-1:0] GAP_BASE  = 3'b100;

  function automatic logic is_null_pair(input logic [PAIR_W-1:0] pair);
    return pair == {NULL_BASE, NULL_BASE};
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// pair_fifo: synchronous FIFO for traceback pairs.
//   clk, rst      clock, asynchronous active-high reset (flushes contents)
//   push          write push_data this cycle (dropped only if full and no pop)
//   push_data     WIDTH-bit entry
//   pop           consume the head entry (ignored when empty)
//   head_vld      FIFO holds at least one entry
//   head          head entry, forced to 0 while empty
//   free          number of unused entries
module pair_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_vld,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] free
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_vld = (count != '0);
  assign head     = head_vld ? mem[rptr] : '0;
  assign free     = CNT_W'(DEPTH) - count;

endmodule

// File: rtl/align_controller.sv
// align_controller: job sequencer for one alignment tile.
// Accepts an R/Q subsequence pair, starts the PE-array scoring pass, then
// enables tbmodule and captures its base pairs into an output FIFO.
// Optional feature macro: ALIGN_CTRL_TIMEOUT_EN enables the traceback
// watchdog (err_timeout); without it err_timeout is tied 0.
//   job_valid/job_ready      job handshake, R_sub_in/Q_sub_in job payload
//   R_sub/Q_sub              latched subsequences for array and tbmodule
//   array_start/array_done   scoring pass start pulse / completion pulse
//   start_traceback          level enable for tbmodule
//   tb_out_r/tb_out_q/tb_finish  tbmodule pair output and finish flag
//   out_valid/out_ready/out_pair/out_last  FIFO head stream
//   busy                     controller not idle
//   err_timeout              sticky watchdog flag
module align_controller
  import align_pkg::*;
#(
  parameter int B          = 4,
  parameter int L          = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TB_TIMEOUT = 2 * L + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [3*L-1:0]    R_sub_in,
  input  logic [3*L-1:0]    Q_sub_in,
  output logic [3*L-1:0]    R_sub,
  output logic [3*L-1:0]    Q_sub,
  output logic              array_start,
  input  logic              array_done,
  output logic              start_traceback,
  input  logic [BASE_W-1:0] tb_out_r,
  input  logic [BASE_W-1:0] tb_out_q,
  input  logic              tb_finish,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PAIR_W-1:0] out_pair,
  output logic              out_last,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (B < 1 || FIFO_DEPTH < 2 * L) begin : g_cfg_check
    $error("align_controller: need B >= 1 and FIFO_DEPTH >= 2*L");
  end

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              space_ok;
  logic              timeout_now;
  logic              push;
  logic [PAIR_W:0]   push_data;
  logic [PAIR_W:0]   head;
  logic [CNT_W-1:0]  fifo_free;
  logic [PAIR_W-1:0] tb_pair;

  assign tb_pair   = {tb_out_r, tb_out_q};
  assign job_ready = (state == ST_IDLE) && !rst;
  assign accept    = job_valid && job_ready;
  // tbmodule cannot stall, so a whole path (up to 2L pairs) must fit first.
  assign space_ok  = (fifo_free >= CNT_W'(2 * L));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      array_start <= 1'b0;
      R_sub       <= '0;
      Q_sub       <= '0;
    end else begin
      state       <= state_nxt;
      array_start <= accept;
      if (accept) begin
        R_sub <= R_sub_in;
        Q_sub <= Q_sub_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = {1'b0, tb_pair};
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_SCORE;
      end
      ST_SCORE: begin
        // WAIT_SPACE is passed through in zero cycles when room already exists.
        if (array_done) state_nxt = space_ok ? ST_TRACE : ST_WAIT_SPACE;
      end
      ST_WAIT_SPACE: begin
        if (space_ok) state_nxt = ST_TRACE;
      end
      ST_TRACE: begin
        if (timeout_now) begin
          push      = 1'b1;
          push_data = {1'b1, NULL_BASE, NULL_BASE};
          state_nxt = ST_IDLE;
        end else if (tb_finish) begin
          // The finishing pair always closes the job, so it is never filtered.
          push      = 1'b1;
          push_data = {1'b1, tb_pair};
          state_nxt = ST_IDLE;
        end else if (!is_null_pair(tb_pair)) begin
          push = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef ALIGN_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TB_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // to_cnt holds the number of TRACE cycles already completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == ST_TRACE) ? to_cnt + 1'b1 : '0;
      if (timeout_now) err_q <= 1'b1;
    end
  end

  assign timeout_now = (state == ST_TRACE) && !tb_finish &&
                       (to_cnt == TO_W'(TB_TIMEOUT - 1));
  assign err_timeout = err_q;
`else
  assign timeout_now = 1'b0;
  assign err_timeout = 1'b0;
`endif

  pair_fifo #(
    .WIDTH (PAIR_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (out_valid && out_ready),
    .head_vld  (out_valid),
    .head      (head),
    .free      (fifo_free)
  );

  assign out_pair        = head[PAIR_W-1:0];
  assign out_last        = head[PAIR_W];
  assign start_traceback = (state == ST_TRACE);
  assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_align_controller.sv
// tb_align_controller: randomized scoreboard bench for align_controller.
// The stimulus thread plays host, scoring array and tbmodule; expected FIFO
// output is derived from the traceback sequence it drives and queued, and a
// monitor pops and compares on every out_valid&&out_ready handshake.
module tb_align_controller;
  import align_pkg::*;

  localparam int L          = 8;
  localparam int TB_TIMEOUT = 2 * L + 4;

  typedef logic [5:0] pair_t;
  typedef pair_t      pair_q_t[$];

  logic           clk = 1'b0;
  logic           rst;
  logic           job_valid;
  logic           job_ready;
  logic [3*L-1:0] R_sub_in, Q_sub_in, R_sub, Q_sub;
  logic           array_start, array_done, start_traceback;
  logic [2:0]     tb_out_r, tb_out_q;
  logic           tb_finish;
  logic           out_valid, out_ready, out_last, busy, err_timeout;
  logic [5:0]     out_pair;

  int             checks   = 0;
  int             failures = 0;
  int             pops     = 0;
  logic [6:0]     exp_q[$];
  bit             exp_err  = 0;
  bit             rand_rdy = 0;

  align_controller dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .R_sub_in(R_sub_in), .Q_sub_in(Q_sub_in), .R_sub(R_sub), .Q_sub(Q_sub),
    .array_start(array_start), .array_done(array_done),
    .start_traceback(start_traceback), .tb_out_r(tb_out_r),
    .tb_out_q(tb_out_q), .tb_finish(tb_finish), .out_valid(out_valid),
    .out_ready(out_ready), .out_pair(out_pair), .out_last(out_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, between driving instants.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {out_last, out_pair}, 7'h00);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        chk("pop_pair", out_pair, e[5:0]);
        chk("pop_last", out_last, e[6]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  function automatic pair_t rnd_pair();
    pair_t p;
    do p = pair_t'($urandom); while (p == {NULL_BASE, NULL_BASE});
    return p;
  endfunction

  task automatic drive_null();
    tb_out_r  = NULL_BASE;
    tb_out_q  = NULL_BASE;
    tb_finish = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy  = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic wait_start(input int max);
    int n = 0;
    while (!start_traceback && n < max) begin
      step();
      n++;
    end
    chk("wait_start", start_traceback, 1'b1);
  endtask

  // Host handshake plus scoring pass; returns just after array_done is sampled.
  task automatic start_job(input logic [3*L-1:0] r, input logic [3*L-1:0] q,
                           input int done_dly);
    chk("job_ready_idle", job_ready, 1'b1);
    R_sub_in  = r;
    Q_sub_in  = q;
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    chk("array_start_pulse", array_start, 1'b1);
    chk("busy_job", busy, 1'b1);
    chk("R_sub", R_sub, r);
    chk("Q_sub", Q_sub, q);
    step();
    chk("array_start_once", array_start, 1'b0);
    repeat (done_dly) step();
    chk("no_tb_before_done", start_traceback, 1'b0);
    array_done = 1'b1;
    step();
    array_done = 1'b0;
  endtask

  // Plays tbmodule from the first enabled cycle; seq[k] is the pair on cycle k,
  // tb_finish is high for cycles fin .. fin+hold-1.
  task automatic trace_job(input pair_q_t seq, input int fin, input int hold);
    int last_k = fin;
    bit to     = 0;
`ifdef ALIGN_CTRL_TIMEOUT_EN
    if (fin > TB_TIMEOUT - 1) begin
      last_k = TB_TIMEOUT - 1;
      to     = 1;
    end
`endif
    for (int k = 0; k <= last_k; k++) begin
      if (k == last_k)
        exp_q.push_back(to ? {1'b1, NULL_BASE, NULL_BASE} : {1'b1, seq[k]});
      else if (seq[k] != {NULL_BASE, NULL_BASE})
        exp_q.push_back({1'b0, seq[k]});
    end
    for (int k = 0; k <= last_k; k++) begin
      tb_out_r  = seq[k][5:3];
      tb_out_q  = seq[k][2:0];
      tb_finish = (k >= fin) && (k < fin + hold);
      step();
      if (k < last_k) chk("tb_held", start_traceback, 1'b1);
    end
    chk("tb_release", start_traceback, 1'b0);
    chk("idle_after_trace", job_ready, 1'b1);
    if (to) exp_err = 1;
    chk("err_timeout", err_timeout, exp_err);
    for (int k = last_k + 1; k < fin + hold; k++) begin
      {tb_out_r, tb_out_q} = rnd_pair();
      tb_finish = 1'b1;
      step();
      chk("no_restart", start_traceback, 1'b0);
    end
    drive_null();
  endtask

  initial begin
    pair_q_t        seq;
    logic [3*L-1:0] r, q;
    int             p0, n, fin;

    rst = 1'b1; job_valid = 1'b0; array_done = 1'b0; out_ready = 1'b0;
    R_sub_in = '0; Q_sub_in = '0;
    drive_null();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_job_ready", job_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_array_start", array_start, 1'b0);
    chk("rst_start_tb", start_traceback, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_R_sub", R_sub, 0);
    rst = 1'b0;
    step();
    chk("post_rst_job_ready", job_ready, 1'b1);

    // array_done outside SCORE has no effect
    array_done = 1'b1;
    step();
    array_done = 1'b0;
    chk("done_ignored_busy", busy, 1'b0);
    chk("done_ignored_tb", start_traceback, 1'b0);

    // Diagonal job: R=Q, eight matched pairs, finish on the eighth
    out_ready = 1'b1;
    for (int i = 0; i < L; i++) r[3*i +: 3] = 3'($urandom_range(0, 3));
    start_job(r, r, 10);
    chk("done_to_tb_latency", start_traceback, 1'b1);
    wait_start(20);
    seq = {};
    seq.push_back({NULL_BASE, NULL_BASE});
    for (int i = 0; i < 8; i++) seq.push_back({r[3*i +: 3], r[3*i +: 3]});
    p0 = pops;
    trace_job(seq, 8, 1);
    drain();
    chk("diag_pop_count", pops - p0, 8);

    // Two leading sentinels are filtered
    start_job(24'($urandom), 24'($urandom), 2);
    chk("done_to_tb_latency", start_traceback, 1'b1);
    wait_start(20);
    seq = {};
    seq.push_back({NULL_BASE, NULL_BASE});
    seq.push_back({NULL_BASE, NULL_BASE});
    for (int i = 0; i < 3; i++) seq.push_back(rnd_pair());
    p0 = pops;
    trace_job(seq, 4, 1);
    drain();
    chk("sentinel_pop_count", pops - p0, 3);

    // Gap path, last on the fourth pair
    start_job(24'($urandom), 24'($urandom), 3);
    wait_start(20);
    seq = {};
    seq.push_back({NULL_BASE, NULL_BASE});
    for (int i = 0; i < 4; i++) seq.push_back({GAP_BASE, 3'($urandom_range(0, 3))});
    p0 = pops;
    trace_job(seq, 4, 1);
    drain();
    chk("gap_pop_count", pops - p0, 4);

    // tb_finish held for five cycles: one last pair only
    start_job(24'($urandom), 24'($urandom), 1);
    wait_start(20);
    seq = {};
    seq.push_back({NULL_BASE, NULL_BASE});
    seq.push_back(rnd_pair());
    seq.push_back(rnd_pair());
    p0 = pops;
    trace_job(seq, 2, 5);
    drain();
    chk("hold_pop_count", pops - p0, 2);

    // Backpressure: ten entries held, next job parks in WAIT_SPACE
    out_ready = 1'b0;
    start_job(24'($urandom), 24'($urandom), 2);
    wait_start(20);
    seq = {};
    seq.push_back({NULL_BASE, NULL_BASE});
    for (int i = 0; i < 10; i++) seq.push_back(rnd_pair());
    trace_job(seq, 10, 1);
    start_job(24'($urandom), 24'($urandom), 2);
    chk("bp_parked", start_traceback, 1'b0);
    chk("bp_busy", busy, 1'b1);
    repeat (3) step();
    chk("bp_still_parked", start_traceback, 1'b0);
    out_ready = 1'b1;
    n = 0;
    while (!start_traceback && n < 40) begin
      step();
      n++;
    end
    chk("bp_release_latency", n, 10 + 1);
    seq = {};
    seq.push_back({NULL_BASE, NULL_BASE});
    seq.push_back(rnd_pair());
    trace_job(seq, 1, 1);
    drain();

    // Randomized jobs under random consumer backpressure
    for (int j = 0; j < 8; j++) begin
      rand_rdy = 1;
      start_job(24'($urandom), 24'($urandom), $urandom_range(1, 6));
      wait_start(300);
      fin = $urandom_range(1, 12);
      seq = {};
      seq.push_back({NULL_BASE, NULL_BASE});
      for (int i = 1; i <= fin; i++)
        seq.push_back((i < fin && $urandom_range(0, 3) == 0) ?
                      {NULL_BASE, NULL_BASE} : rnd_pair());
      trace_job(seq, fin, $urandom_range(1, 3));
    end
    drain();

    // Long stall: no finish for 30 cycles (watchdog fires first when enabled)
    start_job(24'($urandom), 24'($urandom), 2);
    wait_start(20);
    seq = {};
    for (int i = 0; i < 30; i++) seq.push_back({NULL_BASE, NULL_BASE});
    seq.push_back(rnd_pair());
    trace_job(seq, 30, 1);
    drain();

    // Reset in the middle of TRACE with pairs queued
    out_ready = 1'b0;
    start_job(24'($urandom), 24'($urandom), 2);
    wait_start(20);
    drive_null();
    step();
    for (int i = 0; i < 3; i++) begin
      {tb_out_r, tb_out_q} = rnd_pair();
      step();
    end
    chk("pre_rst_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    drive_null();
    exp_q.delete();
    exp_err = 0;
    chk("mid_rst_job_ready", job_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_start_tb", start_traceback, 1'b0);
    chk("mid_rst_array_start", array_start, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out", {out_last, out_pair}, 7'h00);
    chk("mid_rst_err", err_timeout, 1'b0);
    chk("mid_rst_Q_sub", Q_sub, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_mid_rst_ready", job_ready, 1'b1);
    out_ready = 1'b1;
    repeat (5) step();
    chk("post_mid_rst_empty", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
